// File: rtl/fpu_add_sched.sv
// Round-robin scheduler sharing one pipelined FPU adder among NREQ requesters.
// Optional feature: define FPU_SCHED_SUB_EN to let requesters ask for A-B via iSub.
module fpu_add_sched #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 3
) (
    input  logic                            iCLK,
    input  logic                            iRESET,
    input  logic [NREQ-1:0]                 iReq,
    input  logic [NREQ*32-1:0]              iA,
    input  logic [NREQ*32-1:0]              iB,
    input  logic [NREQ-1:0]                 iSub,
    input  logic                            iHold,
    output logic [NREQ-1:0]                 oGnt,
    output logic [31:0]                     oFpuA,
    output logic [31:0]                     oFpuB,
    output logic                            oFpuValid,
    input  logic [31:0]                     iFpuSum,
    output logic [31:0]                     oResult,
    output logic [NREQ-1:0]                 oResValid,
    output logic [$clog2(LATENCY+2)-1:0]    oInFlight
);

    localparam int PW = $clog2(NREQ);
    localparam logic [PW-1:0] LAST_ID = PW'(NREQ - 1);

    logic [PW-1:0] ptr;
    logic          gnt_any;
    logic [PW-1:0] gnt_id;
    int            idx;
    logic [31:0]   a_sel;
    logic [31:0]   b_sel;

    // Tag pipe has LATENCY+1 slots: stage 0 loads with the operand register, and
    // the sum is sampled one edge after the FPU presents it.
    logic          tag_v  [LATENCY+1];
    logic [PW-1:0] tag_id [LATENCY+1];
    logic          ret;
    logic [PW-1:0] ret_id;

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        if (!iHold && !iRESET) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(ptr) + k) % NREQ;
                if (!gnt_any && iReq[idx]) begin
                    gnt_any = 1'b1;
                    gnt_id  = PW'(idx);
                end
            end
        end
    end

    always_comb begin
        oGnt = '0;
        if (gnt_any) oGnt[gnt_id] = 1'b1;
    end

    assign a_sel = iA[32*gnt_id +: 32];

`ifdef FPU_SCHED_SUB_EN
    assign b_sel = {iB[32*gnt_id + 31] ^ iSub[gnt_id], iB[32*gnt_id +: 31]};
`else
    logic unused_sub;
    assign unused_sub = ^iSub;
    assign b_sel = iB[32*gnt_id +: 32];
`endif

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            ptr       <= '0;
            oFpuA     <= '0;
            oFpuB     <= '0;
            oFpuValid <= 1'b0;
        end else begin
            oFpuValid <= gnt_any;
            if (gnt_any) begin
                ptr   <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
                oFpuA <= a_sel;
                oFpuB <= b_sel;
            end
        end
    end

    assign ret    = tag_v[LATENCY];
    assign ret_id = tag_id[LATENCY];

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            for (int i = 0; i <= LATENCY; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= '0;
            end
        end else begin
            tag_v[0]  <= gnt_any;
            tag_id[0] <= gnt_id;
            for (int i = 1; i <= LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            oResult   <= '0;
            oResValid <= '0;
        end else begin
            oResValid <= '0;
            if (ret) begin
                oResult           <= iFpuSum;
                oResValid[ret_id] <= 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            oInFlight <= '0;
        end else begin
            case ({gnt_any, ret})
                2'b10:   oInFlight <= oInFlight + 1'b1;
                2'b01:   oInFlight <= oInFlight - 1'b1;
                default: oInFlight <= oInFlight;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_add_sched.sv
// Directed bench for fpu_add_sched with a table-driven stand-in for the FPU adder.
// Honours FPU_SCHED_SUB_EN for the subtract vector.
module tb_fpu_add_sched;

    localparam int NREQ = 4;
    localparam int L    = 3;
    localparam int IW   = $clog2(L + 2);

    logic                 iCLK = 1'b0;
    logic                 iRESET;
    logic [NREQ-1:0]      iReq;
    logic [NREQ*32-1:0]   iA;
    logic [NREQ*32-1:0]   iB;
    logic [NREQ-1:0]      iSub;
    logic                 iHold;
    logic [NREQ-1:0]      oGnt;
    logic [31:0]          oFpuA;
    logic [31:0]          oFpuB;
    logic                 oFpuValid;
    logic [31:0]          iFpuSum;
    logic [31:0]          oResult;
    logic [NREQ-1:0]      oResValid;
    logic [IW-1:0]        oInFlight;

    int n_cmp = 0;
    int n_err = 0;

    // Expected results, {one-hot owner, sum}, in return order.
    logic [NREQ+31:0] exp_q[$];

    fpu_add_sched #(.NREQ(NREQ), .LATENCY(L)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iReq(iReq), .iA(iA), .iB(iB), .iSub(iSub),
        .iHold(iHold), .oGnt(oGnt), .oFpuA(oFpuA), .oFpuB(oFpuB), .oFpuValid(oFpuValid),
        .iFpuSum(iFpuSum), .oResult(oResult), .oResValid(oResValid), .oInFlight(oInFlight)
    );

    // ---- clock ----
    always #5 iCLK = ~iCLK;

    // ---- FPU stand-in: known float pairs, sum valid LATENCY edges after operands ----
    function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'hC1133333, 32'h40F00000}: return 32'hBFD9999A;  // -9.2 + 7.5
            {32'h40F00000, 32'hC1133333}: return 32'hBFD9999A;  //  7.5 - 9.2
            {32'h40F00000, 32'h41133333}: return 32'h4185999A;  //  7.5 + 9.2
            {32'h3F800000, 32'h3F000000}: return 32'h3FC00000;  //  1.0 + 0.5
            {32'h40000000, 32'h3F000000}: return 32'h40200000;  //  2.0 + 0.5
            {32'h40400000, 32'h3F000000}: return 32'h40600000;  //  3.0 + 0.5
            {32'h40800000, 32'h3F000000}: return 32'h40900000;  //  4.0 + 0.5
            {32'h3F800000, 32'h3F800000}: return 32'h40000000;  //  1.0 + 1.0
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    logic [31:0] fpu_pipe [L];
    always @(posedge iCLK) begin
        fpu_pipe[0] <= fpu_model(oFpuA, oFpuB);
        for (int j = 1; j < L; j++) fpu_pipe[j] <= fpu_pipe[j-1];
    end
    assign iFpuSum = fpu_pipe[L-1];

    // ---- checking ----
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---- scoreboard: every result pulse must match the head of exp_q ----
    always @(negedge iCLK) begin
        logic [NREQ+31:0] e;
        if (!iRESET && oResValid != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_res", 32'(oResValid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_res_id", 32'(oResValid), 32'(e[NREQ+31:32]));
                check("sb_res_val", oResult, e[31:0]);
            end
        end
    end

    // ---- driver tasks ----
    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic sub);
        iA[32*i +: 32] = a;
        iB[32*i +: 32] = b;
        iSub[i]        = sub;
    endtask

    task automatic apply_reset();
        iRESET = 1'b1;
        iReq   = '0;
        iHold  = 1'b0;
        tick();
        tick();
        iRESET = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},      32'(oGnt), 32'd0);
        check({tag, "_fpu_a"},    oFpuA, 32'd0);
        check({tag, "_fpu_b"},    oFpuB, 32'd0);
        check({tag, "_fpu_v"},    32'(oFpuValid), 32'd0);
        check({tag, "_result"},   oResult, 32'd0);
        check({tag, "_resvalid"}, 32'(oResValid), 32'd0);
        check({tag, "_inflight"}, 32'(oInFlight), 32'd0);
    endtask

    // Hand-derived round-robin expectations for requesters 0..3.
    logic [31:0] rr_a   [NREQ] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] rr_sum [NREQ] = '{32'h3FC00000, 32'h40200000, 32'h40600000, 32'h40900000};
    logic [NREQ-1:0] rr_gnt [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0001, 4'b0010, 4'b0100, 4'b1000};
    int rr_inflight [8] = '{1, 2, 3, 4, 4, 4, 4, 4};

    logic [31:0] sub_b_exp;
    logic [31:0] sub_sum_exp;

    initial begin
        iRESET = 1'b1;
        iReq   = '0;
        iA     = '0;
        iB     = '0;
        iSub   = '0;
        iHold  = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        check_all_zero("reset");
        iRESET = 1'b0;
        tick();

        // ---- single add: grant immediately, result LATENCY+1 edges later ----
        set_req(0, 32'hC1133333, 32'h40F00000, 1'b0);
        iReq = 4'b0001;
        #1;
        check("single_gnt", 32'(oGnt), 32'h1);
        exp_q.push_back({4'b0001, 32'hBFD9999A});
        tick();
        iReq = '0;
        check("single_fpu_v", 32'(oFpuValid), 32'd1);
        check("single_fpu_a", oFpuA, 32'hC1133333);
        check("single_fpu_b", oFpuB, 32'h40F00000);
        check("single_inflight", 32'(oInFlight), 32'd1);
        for (int c = 1; c <= L + 1; c++) begin
            tick();
            if (c <= L) check("single_early", 32'(oResValid), 32'd0);
        end
        check("single_resvalid", 32'(oResValid), 32'h1);
        check("single_result", oResult, 32'hBFD9999A);
        tick();
        check("single_pulse_end", 32'(oResValid), 32'd0);
        check("single_idle", 32'(oInFlight), 32'd0);

        // ---- round robin: all four requesting for 8 cycles ----
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, rr_a[i], 32'h3F000000, 1'b0);
        iReq = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            #1;
            check("rr_gnt", 32'(oGnt), 32'(rr_gnt[n]));
            exp_q.push_back({rr_gnt[n], rr_sum[n % NREQ]});
            tick();
            check("rr_inflight", 32'(oInFlight), rr_inflight[n]);
        end
        iReq = '0;
        for (int c = 0; c < L + 2; c++) tick();
        check("rr_drained_q", exp_q.size(), 32'd0);
        check("rr_idle", 32'(oInFlight), 32'd0);

        // ---- hold: pending request 2 waits, then wins on release ----
        set_req(2, 32'h3F800000, 32'h3F800000, 1'b0);
        iHold = 1'b1;
        iReq  = 4'b0100;
        #1;
        check("hold_gnt", 32'(oGnt), 32'd0);
        tick();
        check("hold_fpu_v", 32'(oFpuValid), 32'd0);
        check("hold_inflight", 32'(oInFlight), 32'd0);
        iHold = 1'b0;
        #1;
        check("unhold_gnt", 32'(oGnt), 32'h4);
        exp_q.push_back({4'b0100, 32'h40000000});
        tick();
        iReq = '0;
        check("unhold_fpu_v", 32'(oFpuValid), 32'd1);
        check("unhold_fpu_a", oFpuA, 32'h3F800000);
        for (int c = 0; c < L + 2; c++) tick();
        check("hold_drained_q", exp_q.size(), 32'd0);

        // ---- reset mid-flight: three issues, then async reset ----
        iReq = 4'b1111;
        tick();
        tick();
        tick();
        iReq = '0;
        check("mid_inflight", 32'(oInFlight), 32'd3);
        tick();
        iRESET = 1'b1;
        #1;
        check_all_zero("mid_reset");
        tick();
        iRESET = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("post_rst_no_pulse", 32'(oResValid), 32'd0);
        end

        // ---- subtract select on requester 1 ----
`ifdef FPU_SCHED_SUB_EN
        sub_b_exp   = 32'h41133333;
        sub_sum_exp = 32'h4185999A;
`else
        sub_b_exp   = 32'hC1133333;
        sub_sum_exp = 32'hBFD9999A;
`endif
        set_req(1, 32'h40F00000, 32'hC1133333, 1'b1);
        iReq = 4'b0010;
        #1;
        check("sub_gnt", 32'(oGnt), 32'h2);
        exp_q.push_back({4'b0010, sub_sum_exp});
        tick();
        iReq = '0;
        iSub = '0;
        check("sub_fpu_b", oFpuB, sub_b_exp);
        for (int c = 1; c <= L + 1; c++) tick();
        check("sub_resvalid", 32'(oResValid), 32'h2);
        check("sub_result", oResult, sub_sum_exp);
        tick();
        tick();
        check("final_q_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ---- watchdog ----
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
